// File: rtl/jesd_sysref_ctrl.sv
// rtl/jesd_sysref_ctrl.sv - JESD204B RX SYSREF sequencer with LMFC counter, sync filter and link FSM
module jesd_sysref_ctrl #(
  parameter int F         = 4,
  parameter int K         = 32,
  parameter int PULSES    = 4,
  parameter int SYNC_FILT = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic       clock_i,
  input  logic       rst_n_i,
  input  logic       enable_i,
  input  logic       arm_i,
  input  logic [1:0] mode_i,
  input  logic       rx_dev_sync_n_i,
  output logic       sysref_o,
  output logic       lmfc_pulse_o,
  output logic       link_up_o,
  output logic       busy_o,
  output logic       timeout_err_o,
  output logic [7:0] resync_cnt_o,
  output logic [2:0] state_o
);

  localparam int          P         = K * F / 4;
  localparam logic [8:0]  LMFC_LAST = 9'(P - 1);
  localparam logic [7:0]  FILT_LAST = 8'(SYNC_FILT - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [3:0]  BURST_N   = 4'(PULSES);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_ALIGN  = 3'd2;
  localparam logic [2:0] ST_LOCKED = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  localparam logic [1:0] MODE_ONE  = 2'd1;
  localparam logic [1:0] MODE_CONT = 2'd3;

  logic [8:0]  lmfc_cnt_q, lmfc_cnt_d;
  logic        lmfc_pulse_q;
  logic [7:0]  filt_cnt_q, filt_cnt_d;
  logic        sync_f_q, sync_f_d;
  logic [2:0]  state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] tmo_q, tmo_d;
  logic [3:0]  pulse_cnt_q, pulse_cnt_d;
  logic        sysref_q, sysref_d;
  logic        terr_q, terr_d;
  logic [7:0]  resync_q, resync_d;

  logic        lmfc_edge;
  logic        arm_ok;
  logic [3:0]  budget;
  logic        pulses_left;

  assign lmfc_edge   = (lmfc_cnt_q == 9'd0);
  assign arm_ok      = arm_i && (mode_i != 2'd0);
  assign budget      = (mode_q == MODE_ONE) ? 4'd1 : BURST_N;
  assign pulses_left = (mode_q == MODE_CONT) || (pulse_cnt_q < budget);

  always_comb begin
    lmfc_cnt_d = lmfc_edge ? LMFC_LAST : lmfc_cnt_q - 9'd1;
  end

  // A new sync level is accepted only after SYNC_FILT consecutive samples of it
  always_comb begin
    sync_f_d   = sync_f_q;
    filt_cnt_d = 8'd0;
    if (rx_dev_sync_n_i != sync_f_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        sync_f_d = rx_dev_sync_n_i;
      end else begin
        filt_cnt_d = filt_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    tmo_d       = tmo_q;
    pulse_cnt_d = pulse_cnt_q;
    sysref_d    = 1'b0;
    terr_d      = terr_q;
    resync_d    = resync_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERR: begin
          if (arm_ok) begin
            state_d     = ST_WAIT;
            mode_d      = mode_i;
            terr_d      = 1'b0;
            pulse_cnt_d = 4'd0;
            tmo_d       = 16'd0;
          end
        end
        ST_WAIT: begin
          if (!sync_f_q) begin
            state_d = ST_ALIGN;
            tmo_d   = 16'd0;
          end else if (tmo_q == TMO_LAST) begin
            state_d = ST_ERR;
            terr_d  = 1'b1;
            tmo_d   = 16'd0;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
        ST_ALIGN: begin
          if (lmfc_edge && pulses_left) begin
            sysref_d = 1'b1;
            if (mode_q != MODE_CONT) pulse_cnt_d = pulse_cnt_q + 4'd1;
          end
          if (sync_f_q) state_d = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (!sync_f_q) begin
            state_d     = ST_WAIT;
            pulse_cnt_d = 4'd0;
            tmo_d       = 16'd0;
            if (resync_q != 8'hFF) resync_d = resync_q + 8'd1;
          end else if (lmfc_edge && (mode_q == MODE_CONT)) begin
            sysref_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (!rst_n_i) begin
      lmfc_cnt_q   <= LMFC_LAST;
      lmfc_pulse_q <= 1'b0;
      filt_cnt_q   <= 8'd0;
      sync_f_q     <= 1'b1;
      state_q      <= ST_IDLE;
      mode_q       <= 2'd0;
      tmo_q        <= 16'd0;
      pulse_cnt_q  <= 4'd0;
      sysref_q     <= 1'b0;
      terr_q       <= 1'b0;
      resync_q     <= 8'd0;
    end else begin
      lmfc_cnt_q   <= lmfc_cnt_d;
      lmfc_pulse_q <= lmfc_edge;
      filt_cnt_q   <= filt_cnt_d;
      sync_f_q     <= sync_f_d;
      state_q      <= state_d;
      mode_q       <= mode_d;
      tmo_q        <= tmo_d;
      pulse_cnt_q  <= pulse_cnt_d;
      sysref_q     <= sysref_d;
      terr_q       <= terr_d;
      resync_q     <= resync_d;
    end
  end

  assign sysref_o      = sysref_q;
  assign lmfc_pulse_o  = lmfc_pulse_q;
  assign link_up_o     = (state_q == ST_LOCKED);
  assign busy_o        = (state_q == ST_WAIT) || (state_q == ST_ALIGN) || (state_q == ST_LOCKED);
  assign timeout_err_o = terr_q;
  assign resync_cnt_o  = resync_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_jesd_sysref_ctrl.sv
// tb/tb_jesd_sysref_ctrl.sv - directed self-checking bench for jesd_sysref_ctrl
module tb_jesd_sysref_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, enable, arm, sync_n;
  logic [1:0] mode;
  logic       sysref, lmfc_pulse, link_up, busy, timeout_err;
  logic [7:0] resync_cnt;
  logic [2:0] state;

  int cyc, n_chk, n_pass, sr_seen;
  int pulse_cyc [10];

  typedef struct {
    logic       en;
    logic       arm;
    logic [1:0] mode;
    logic [2:0] st;
    logic       bz;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  jesd_sysref_ctrl dut (
    .clock_i        (clk),
    .rst_n_i        (rst_n),
    .enable_i       (enable),
    .arm_i          (arm),
    .mode_i         (mode),
    .rx_dev_sync_n_i(sync_n),
    .sysref_o       (sysref),
    .lmfc_pulse_o   (lmfc_pulse),
    .link_up_o      (link_up),
    .busy_o         (busy),
    .timeout_err_o  (timeout_err),
    .resync_cnt_o   (resync_cnt),
    .state_o        (state)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
  endtask

  function automatic int sr_due(input int c);
    for (int i = 0; i < 10; i++) if (pulse_cyc[i] == c) return 1;
    return 0;
  endfunction

  // Every cycle: LMFC boundary every 32 cycles and sysref only on the expected boundaries
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sysref) sr_seen++;
    chk("lmfc_pulse", int'(lmfc_pulse), int'(cyc % 32 == 0));
    chk("sysref", int'(sysref), sr_due(cyc));
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  initial begin
    pulse_cyc = '{96, 128, 160, 192, 320, 352, 384, 416, 448, 4608};
    tbl[0] = '{en: 1'b0, arm: 1'b1, mode: 2'd2, st: 3'd0, bz: 1'b0};
    tbl[1] = '{en: 1'b1, arm: 1'b0, mode: 2'd0, st: 3'd0, bz: 1'b0};
    tbl[2] = '{en: 1'b1, arm: 1'b1, mode: 2'd0, st: 3'd0, bz: 1'b0};
    tbl[3] = '{en: 1'b1, arm: 1'b0, mode: 2'd0, st: 3'd0, bz: 1'b0};
    tbl[4] = '{en: 1'b1, arm: 1'b1, mode: 2'd1, st: 3'd1, bz: 1'b1};
    tbl[5] = '{en: 1'b1, arm: 1'b0, mode: 2'd0, st: 3'd2, bz: 1'b1};

    n_chk = 0; n_pass = 0; sr_seen = 0; cyc = 0;
    enable = 1'b1; arm = 1'b0; mode = 2'd0; sync_n = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sysref", int'(sysref), 0);
    chk("rst_lmfc", int'(lmfc_pulse), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_link_up", int'(link_up), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_terr", int'(timeout_err), 0);
    chk("rst_resync", int'(resync_cnt), 0);
    rst_n = 1'b1;

    step_to(70);
    chk("idle_state", int'(state), 0);

    // Burst arm with sync requested
    arm = 1'b1; mode = 2'd2; sync_n = 1'b0;
    step();
    arm = 1'b0; mode = 2'd0;
    chk("burst_wait", int'(state), 1);
    chk("burst_busy", int'(busy), 1);
    step_to(78);
    chk("burst_wait_end", int'(state), 1);
    step();
    chk("burst_align", int'(state), 2);
    step_to(260);
    chk("burst_count", sr_seen, 4);
    chk("burst_still_align", int'(state), 2);

    // Lock, then a 7-cycle glitch that must be filtered
    sync_n = 1'b1;
    step_to(268);
    chk("lock_pre", int'(state), 2);
    step();
    chk("lock_state", int'(state), 3);
    chk("lock_link_up", int'(link_up), 1);
    step();
    sync_n = 1'b0;
    step_to(277);
    sync_n = 1'b1;
    step_to(300);
    chk("glitch_state", int'(state), 3);
    chk("glitch_resync", int'(resync_cnt), 0);

    // Continuous mode, lock, drop and re-align
    enable = 1'b0;
    step();
    chk("dis_idle", int'(state), 0);
    enable = 1'b1; arm = 1'b1; mode = 2'd3;
    step();
    arm = 1'b0; mode = 2'd0;
    chk("cont_wait", int'(state), 1);
    sync_n = 1'b0;
    step_to(310);
    chk("cont_wait_end", int'(state), 1);
    step();
    chk("cont_align", int'(state), 2);
    step_to(325);
    sync_n = 1'b1;
    step_to(334);
    chk("cont_locked", int'(state), 3);
    step_to(390);
    sync_n = 1'b0;
    step_to(398);
    chk("drop_pre", int'(state), 3);
    step();
    chk("drop_wait", int'(state), 1);
    chk("drop_resync", int'(resync_cnt), 1);
    step();
    chk("drop_realign", int'(state), 2);
    step_to(450);
    chk("cont_count", sr_seen, 9);

    // Timeout path
    enable = 1'b0; sync_n = 1'b1;
    step();
    chk("tmo_idle", int'(state), 0);
    chk("tmo_resync_kept", int'(resync_cnt), 1);
    enable = 1'b1;
    step_to(460);
    arm = 1'b1; mode = 2'd1;
    step();
    arm = 1'b0; mode = 2'd0;
    chk("tmo_wait", int'(state), 1);
    step_to(4556);
    chk("tmo_wait_last", int'(state), 1);
    chk("tmo_err_clear", int'(timeout_err), 0);
    step();
    chk("tmo_err_state", int'(state), 4);
    chk("tmo_err_flag", int'(timeout_err), 1);
    chk("tmo_err_busy", int'(busy), 0);
    step_to(4560);
    chk("tmo_err_held", int'(timeout_err), 1);
    arm = 1'b1; mode = 2'd1;
    step();
    arm = 1'b0; mode = 2'd0;
    chk("rearm_state", int'(state), 1);
    chk("rearm_terr", int'(timeout_err), 0);
    sync_n = 1'b0;
    step_to(4569);
    chk("rearm_wait_end", int'(state), 1);
    step();
    chk("rearm_align", int'(state), 2);
    step_to(4575);

    // enable=0 with arm on the cycle before a due pulse, mode=0 arm, then one-shot
    for (int i = 0; i < 6; i++) begin
      enable = tbl[i].en; arm = tbl[i].arm; mode = tbl[i].mode;
      step();
      chk($sformatf("tbl%0d_state", i), int'(state), int'(tbl[i].st));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].bz));
    end
    enable = 1'b1; arm = 1'b0; mode = 2'd0;
    step_to(4650);
    chk("oneshot_count", sr_seen, 10);
    chk("oneshot_state", int'(state), 2);
    chk("final_resync", int'(resync_cnt), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
